// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with load/clamp, start/stop control and a registered done pulse.
// Optional periodic reload on terminal count: define COUNTDOWN_AUTORELOAD_EN.

module bcd_digit #(
  parameter logic [3:0] MAX_VAL = 4'd9
) (
  input  logic [3:0] cur,
  input  logic [3:0] ld_raw,
  output logic [3:0] dec,
  output logic       is_zero,
  output logic [3:0] ld_val,
  output logic       ld_clamped
);
  assign is_zero    = (cur == 4'd0);
  assign dec        = is_zero ? 4'd9 : cur - 4'd1;
  assign ld_clamped = (ld_raw > MAX_VAL);
  assign ld_val     = ld_clamped ? MAX_VAL : ld_raw;
endmodule

module bcd_countdown_timer #(
  parameter int DIGITS  = 2,
  parameter int MSD_MAX = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                start,
  input  logic                stop,
  output logic [4*DIGITS-1:0] q_bus,
  output logic                running,
  output logic                done,
  output logic                load_error
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic [4*DIGITS-1:0] reload_q, reload_d;
  logic                done_q, done_d;
  logic                load_error_q, load_error_d;

  logic [4*DIGITS-1:0] dig_dec, dec_cnt, clamp_val;
  logic [DIGITS-1:0]   dig_zero, borrow, clamp_hit;
  logic                cnt_zero;

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    localparam logic [3:0] MAXV = (i == DIGITS-1) ? 4'(MSD_MAX) : 4'd9;

    bcd_digit #(.MAX_VAL(MAXV)) u_dig (
      .cur        (cnt_q[4*i +: 4]),
      .ld_raw     (load_value[4*i +: 4]),
      .dec        (dig_dec[4*i +: 4]),
      .is_zero    (dig_zero[i]),
      .ld_val     (clamp_val[4*i +: 4]),
      .ld_clamped (clamp_hit[i])
    );

    // A digit only moves when every digit below it is already zero.
    assign dec_cnt[4*i +: 4] = borrow[i] ? dig_dec[4*i +: 4] : cnt_q[4*i +: 4];

    if (i < DIGITS-1) begin : g_borrow
      assign borrow[i+1] = borrow[i] & dig_zero[i];
    end
  end

  assign cnt_zero = &dig_zero;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reload_d     = reload_q;
    done_d       = 1'b0;
    load_error_d = 1'b0;
    if (load) begin
      cnt_d        = clamp_val;
      reload_d     = clamp_val;
      state_d      = ST_IDLE;
      load_error_d = |clamp_hit;
    end else if (stop) begin
      if (state_q != ST_IDLE) state_d = ST_HOLD;
    end else if (start && state_q != ST_RUN) begin
      state_d = ST_RUN;
    end else if (tick && state_q == ST_RUN) begin
      if (cnt_zero) begin
        done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        cnt_d = reload_q;
`else
        state_d = ST_IDLE;
`endif
      end else begin
        cnt_d = dec_cnt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      reload_q     <= '0;
      done_q       <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reload_q     <= reload_d;
      done_q       <= done_d;
      load_error_q <= load_error_d;
    end
  end

  assign q_bus      = cnt_q;
  assign running    = (state_q == ST_RUN);
  assign done       = done_q;
  assign load_error = load_error_q;
endmodule
